// File: rtl/ps2_pkg.sv
// Shared encodings for the PS/2 mouse packet assembler.
package ps2_pkg;

    // Position within a 3-byte stream-mode packet.
    typedef enum logic [1:0] {
        S_B0 = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2
    } ps2_state_t;

    // Status bytes the mouse may send in stream mode; they are not packet data.
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;

    // Flags-byte bit positions.
    localparam int FLG_LEFT    = 0;
    localparam int FLG_RIGHT   = 1;
    localparam int FLG_MIDDLE  = 2;
    localparam int FLG_ALWAYS1 = 3;
    localparam int FLG_XSIGN   = 4;
    localparam int FLG_YSIGN   = 5;
    localparam int FLG_XOVF    = 6;
    localparam int FLG_YOVF    = 7;

    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_BAT_OK);
    endfunction

endpackage

// File: rtl/pos_clamp_acc.sv
// Single-axis cursor accumulator: adds (or subtracts) a 9-bit signed delta,
// ignores the delta when its overflow flag is set, and clamps to 0..LIMIT-1.
module pos_clamp_acc #(
    parameter int LIMIT  = 640,
    parameter int POS_W  = 10,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit,
    input  logic [8:0]       delta,
    input  logic             ovf,
    output logic [POS_W-1:0] pos
);
    import ps2_pkg::*;

    localparam logic [POS_W-1:0]  INIT  = POS_W'(LIMIT / 2);
    localparam logic [POS_W-1:0]  MAX_U = POS_W'(LIMIT - 1);
    localparam logic signed [11:0] MAX_S = 12'(LIMIT - 1);

    logic signed [11:0] d_eff;
    logic signed [11:0] cur;
    logic signed [11:0] nxt;
    logic [POS_W-1:0]   clamped;

    // Candidate position with 12-bit signed headroom, then clamp to the screen.
    always_comb begin
        d_eff   = ovf ? 12'sd0 : {{3{delta[8]}}, delta};
        cur     = signed'(12'(pos));
        nxt     = INVERT ? (cur - d_eff) : (cur + d_eff);
        clamped = nxt[POS_W-1:0];
        if (nxt < 12'sd0) begin
            clamped = '0;
        end else if (nxt > MAX_S) begin
            clamped = MAX_U;
        end
    end

    // Position register, updated only when a packet commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos <= INIT;
        end else if (commit) begin
            pos <= clamped;
        end
    end

endmodule

// File: rtl/ps2_mouse_packet.sv
// Assembles PS/2 stream-mode bytes into 3-byte mouse packets, decodes them and
// tracks a clamped absolute cursor position.
//
// Input handshake: rx_done is a one-cycle strobe with rx_data valid in the same
// cycle. There is no ready/back-pressure; every strobe is consumed, including
// strobes on consecutive cycles.
module ps2_mouse_packet #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int POS_W          = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              pkt_valid,
    output logic              btn_left,
    output logic              btn_right,
    output logic              btn_middle,
    output logic signed [8:0] dx,
    output logic signed [8:0] dy,
    output logic              x_ovf,
    output logic              y_ovf,
    output logic [POS_W-1:0]  pos_x,
    output logic [POS_W-1:0]  pos_y,
    output logic              sync_err,
    output logic [1:0]        state_dbg
);
    import ps2_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t       state, state_nx;
    logic [7:0]       flags_q;
    logic [7:0]       x_q;
    logic [CNT_W-1:0] idle_cnt;
    logic             timeout_hit;
    logic             latch_flags, latch_x, commit, framing_err, timeout;
    logic [8:0]       dx_new, dy_new;

    assign state_dbg   = state;
    // rx_done wins over an expiring timer in the same cycle.
    assign timeout_hit = (idle_cnt == CNT_MAX) && !rx_done;
    assign dx_new      = {flags_q[FLG_XSIGN], x_q};
    assign dy_new      = {flags_q[FLG_YSIGN], rx_data};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_B0;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_nx    = state;
        latch_flags = 1'b0;
        latch_x     = 1'b0;
        commit      = 1'b0;
        framing_err = 1'b0;
        timeout     = 1'b0;
        case (state)
            S_B0: begin
                if (rx_done) begin
                    if (is_status_byte(rx_data)) begin
                        state_nx = S_B0;
                    end else if (!rx_data[FLG_ALWAYS1]) begin
                        framing_err = 1'b1;
                    end else begin
                        latch_flags = 1'b1;
                        state_nx    = S_B1;
                    end
                end
            end
            S_B1: begin
                if (rx_done) begin
                    latch_x  = 1'b1;
                    state_nx = S_B2;
                end else if (timeout_hit) begin
                    timeout  = 1'b1;
                    state_nx = S_B0;
                end
            end
            S_B2: begin
                if (rx_done) begin
                    commit   = 1'b1;
                    state_nx = S_B0;
                end else if (timeout_hit) begin
                    timeout  = 1'b1;
                    state_nx = S_B0;
                end
            end
            default: state_nx = S_B0;
        endcase
    end

    // Idle counter: cleared by every byte, saturates at the timeout value.
    always_ff @(posedge clk) begin
        if (reset || rx_done) begin
            idle_cnt <= '0;
        end else if (idle_cnt != CNT_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Byte capture, decoded outputs and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q    <= '0;
            x_q        <= '0;
            pkt_valid  <= 1'b0;
            sync_err   <= 1'b0;
            btn_left   <= 1'b0;
            btn_right  <= 1'b0;
            btn_middle <= 1'b0;
            dx         <= '0;
            dy         <= '0;
            x_ovf      <= 1'b0;
            y_ovf      <= 1'b0;
        end else begin
            pkt_valid <= commit;
            sync_err  <= framing_err | timeout;
            if (latch_flags) flags_q <= rx_data;
            if (latch_x)     x_q     <= rx_data;
            if (commit) begin
                btn_left   <= flags_q[FLG_LEFT];
                btn_right  <= flags_q[FLG_RIGHT];
                btn_middle <= flags_q[FLG_MIDDLE];
                dx         <= dx_new;
                dy         <= dy_new;
                x_ovf      <= flags_q[FLG_XOVF];
                y_ovf      <= flags_q[FLG_YOVF];
            end
        end
    end

    pos_clamp_acc #(.LIMIT(SCREEN_W), .POS_W(POS_W), .INVERT(1'b0)) u_acc_x (
        .clk    (clk),
        .reset  (reset),
        .commit (commit),
        .delta  (dx_new),
        .ovf    (flags_q[FLG_XOVF]),
        .pos    (pos_x)
    );

    // Screen Y grows downward while mouse dy is positive upward.
    pos_clamp_acc #(.LIMIT(SCREEN_H), .POS_W(POS_W), .INVERT(1'b1)) u_acc_y (
        .clk    (clk),
        .reset  (reset),
        .commit (commit),
        .delta  (dy_new),
        .ovf    (flags_q[FLG_YOVF]),
        .pos    (pos_y)
    );

endmodule
